aes_decipher_iter: RTL

AES_DECIPHER_ITER -- requirements
Module: aes_decipher_iter

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_inv_round.sv | 47 ++++
 rtl/aes_decipher_iter.sv | 115 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared state encoding, inverse S-box table and GF(2^8) helpers
// used by the iterative AES decipher datapath.
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Inverse S-box, entry b at index b (index 0 is the leftmost byte).
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

   // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant (enough for the 9/11/13/14 InvMixColumns factors).
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] a2, a4, a8;
      a2 = xtime(a);
      a4 = xtime(a2);
      a8 = xtime(a4);
      return (c[0] ? a  : 8'h00) ^ (c[1] ? a2 : 8'h00) ^
             (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES decryption round.
// InvShiftRows and InvSubBytes, add round key, then InvMixColumns unless last.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] rkey,
   input  logic         last,
   output logic [127:0] result
);

   logic [127:0] added;

   // InvMixColumns on one column (bytes s0..s3 from msb down).
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] s0, s1, s2, s3;
      s0 = col[31:24];
      s1 = col[23:16];
      s2 = col[15:8];
      s3 = col[7:0];
      return {gmul(s0, 4'd14) ^ gmul(s1, 4'd11) ^ gmul(s2, 4'd13) ^ gmul(s3, 4'd9),
              gmul(s0, 4'd9)  ^ gmul(s1, 4'd14) ^ gmul(s2, 4'd11) ^ gmul(s3, 4'd13),
              gmul(s0, 4'd13) ^ gmul(s1, 4'd9)  ^ gmul(s2, 4'd14) ^ gmul(s3, 4'd11),
              gmul(s0, 4'd11) ^ gmul(s1, 4'd13) ^ gmul(s2, 4'd9)  ^ gmul(s3, 4'd14)};
   endfunction

   // Row r rotates right by r columns; byte (row r, col c) sits at index 4c+r.
   always_comb begin
      added = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            added[127-8*(4*c+r) -: 8] =
               inv_sbox(state[127-8*(4*((c+4-r)%4)+r) -: 8]) ^ rkey[127-8*(4*c+r) -: 8];
         end
      end
   end

   // Final round skips the column mix.
   always_comb begin
      result = '0;
      for (int c = 0; c < 4; c++) begin
         result[127-32*c -: 32] = last ? added[127-32*c -: 32]
                                       : inv_mix_col(added[127-32*c -: 32]);
      end
   end

endmodule

// File: rtl/aes_decipher_iter.sv
// aes_decipher_iter: iterative AES-128/192/256 decipher, one round per clock.
// The key schedule is supplied pre-expanded in decryption order and latched
// at acceptance so the producer may change its inputs while rounds run.
module aes_decipher_iter
   import aes_pkg::*;
#(
   parameter  int NK = 4,
   localparam int NR = NK + 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [127:0]            in,
   input  logic [128*(NR+1)-1:0]   word,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [127:0]            out,
   output logic                    busy
);

   localparam int            RW       = $clog2(NR + 1);
   localparam logic [RW-1:0] LAST_RND = RW'(NR);
   localparam logic [RW-1:0] FIRST_RND = RW'(1);

   state_t                  fsm, fsm_next;
   logic [RW-1:0]           rnd, rnd_next;
   logic                    load, step, last;
   logic [127:0]            blk;
   logic [128*(NR+1)-1:0]   key_q;
   logic [127:0]            rkey, round_res;

   assign last = (rnd == LAST_RND);
   assign rkey = key_q[128*rnd +: 128];

   assign in_ready  = !rst && ((fsm == ST_IDLE) || ((fsm == ST_DONE) && out_ready));
   assign out_valid = (fsm == ST_DONE);
   assign busy      = (fsm == ST_RUN);
   assign out       = blk;

   aes_inv_round u_round (
      .state  (blk),
      .rkey   (rkey),
      .last   (last),
      .result (round_res)
   );

   // Next-state logic: acceptance, round stepping and output handshake.
   always_comb begin
      fsm_next = fsm;
      rnd_next = rnd;
      load     = 1'b0;
      step     = 1'b0;
      unique case (fsm)
         ST_IDLE: begin
            if (in_valid) begin
               load     = 1'b1;
               fsm_next = ST_RUN;
               rnd_next = FIRST_RND;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (last) begin
               fsm_next = ST_DONE;
               rnd_next = '0;
            end else begin
               rnd_next = rnd + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  load     = 1'b1;
                  fsm_next = ST_RUN;
                  rnd_next = FIRST_RND;
               end else begin
                  fsm_next = ST_IDLE;
               end
            end
         end
         default: fsm_next = ST_IDLE;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm <= ST_IDLE;
         rnd <= '0;
      end else begin
         fsm <= fsm_next;
         rnd <= rnd_next;
      end
   end

   // State register: initial key add at acceptance, one round per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         blk <= '0;
      end else if (load) begin
         blk <= in ^ word[127:0];
      end else if (step) begin
         blk <= round_res;
      end
   end

   // Private copy of the key schedule, taken only at acceptance.
   always_ff @(posedge clk) begin
      if (load && !rst) begin
         key_q <= word;
      end
   end

endmodule
